// File: rtl/execute_stage_if.sv
// -----------------------------------------------------------------------------
// execute_stage_if
//   Bundle between the pipeline and the Y86-64 execute stage.
//   - E-register fields (E_*) entering the execute stage.
//   - Hazard/status inputs: m_stat, W_stat, M_bubble.
//   - Same-cycle results to decode forwarding and pipeline control (e_*).
//   - Registered M-register fields (M_*) and the condition codes (cc).
//   Modports:
//     master : pipeline side, drives E_* and the control inputs, observes results.
//     slave  : execute stage side.
// -----------------------------------------------------------------------------
interface execute_stage_if #(
    parameter int W = 64
);
    logic [2:0]   E_stat;
    logic [3:0]   E_icode;
    logic [3:0]   E_ifun;
    logic [W-1:0] E_valC;
    logic [W-1:0] E_valA;
    logic [W-1:0] E_valB;
    logic [3:0]   E_dstE;
    logic [3:0]   E_dstM;
    logic [2:0]   m_stat;
    logic [2:0]   W_stat;
    logic         M_bubble;
    logic [W-1:0] e_valE;
    logic [3:0]   e_dstE;
    logic         e_Cnd;
    logic [2:0]   M_stat;
    logic [3:0]   M_icode;
    logic         M_Cnd;
    logic [W-1:0] M_valE;
    logic [W-1:0] M_valA;
    logic [3:0]   M_dstE;
    logic [3:0]   M_dstM;
    logic [2:0]   cc;

    modport master (
        output E_stat, E_icode, E_ifun, E_valC, E_valA, E_valB, E_dstE, E_dstM,
        output m_stat, W_stat, M_bubble,
        input  e_valE, e_dstE, e_Cnd,
        input  M_stat, M_icode, M_Cnd, M_valE, M_valA, M_dstE, M_dstM, cc
    );

    modport slave (
        input  E_stat, E_icode, E_ifun, E_valC, E_valA, E_valB, E_dstE, E_dstM,
        input  m_stat, W_stat, M_bubble,
        output e_valE, e_dstE, e_Cnd,
        output M_stat, M_icode, M_Cnd, M_valE, M_valA, M_dstE, M_dstM, cc
    );
endinterface

// File: rtl/execute_stage.sv
// -----------------------------------------------------------------------------
// execute_stage
//   Y86-64 execute stage and E->M pipeline register. Selects ALU operands from
//   the E register, computes valE, owns the {ZF,SF,OF} condition codes,
//   evaluates jXX/cmovXX conditions and registers the result into M.
//   Ports:
//     clk   : rising-edge clock
//     rst_n : asynchronous active-low reset (cc=3'b100, M holds a bubble)
//     bus   : execute_stage_if.slave (E_* in, m_stat/W_stat/M_bubble in,
//             e_valE/e_dstE/e_Cnd combinational out, M_* and cc registered out)
//   Build option:
//     EXEC_EXT_ALU_EN : adds OPq ifun 4 (or), 5 (shl), 6 (logical shr).
//     Without it, OPq ifun 4..F are unsupported and raise INS.
// -----------------------------------------------------------------------------
module execute_stage #(
    parameter int         W     = 64,
    parameter logic [3:0] RNONE = 4'hF
) (
    input  logic            clk,
    input  logic            rst_n,
    execute_stage_if.slave  bus
);
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    localparam logic [2:0] S_AOK = 3'd1;
    localparam logic [2:0] S_HLT = 3'd2;
    localparam logic [2:0] S_ADR = 3'd3;
    localparam logic [2:0] S_INS = 3'd4;

    function automatic logic ovf_add(input logic signed [W-1:0] a,
                                     input logic signed [W-1:0] b,
                                     input logic signed [W-1:0] r);
        return (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
    endfunction

    // r = b - a overflows when the operands disagree in sign and r leaves b's sign.
    function automatic logic ovf_sub(input logic signed [W-1:0] a,
                                     input logic signed [W-1:0] b,
                                     input logic signed [W-1:0] r);
        return (a[W-1] != b[W-1]) && (r[W-1] != b[W-1]);
    endfunction

    function automatic logic stat_exc(input logic [2:0] s);
        return (s == S_HLT) || (s == S_ADR) || (s == S_INS);
    endfunction

    logic signed [W-1:0] alu_a_p0;
    logic signed [W-1:0] alu_b_p0;
    logic signed [W-1:0] alu_r_p0;
    logic [3:0]          alu_fun_p0;
    logic                alu_of_p0;
    logic                alu_ok_p0;
    logic                op_bad_p0;
    logic                set_cc_p0;
    logic                cnd_p0;
    logic [3:0]          dst_e_p0;
    logic [2:0]          stat_p0;

    logic [2:0]          cc_p1;
    logic [2:0]          stat_p1;
    logic [3:0]          icode_p1;
    logic                cnd_p1;
    logic [W-1:0]        val_e_p1;
    logic [W-1:0]        val_a_p1;
    logic [3:0]          dst_e_p1;
    logic [3:0]          dst_m_p1;

    // ---- stage p0: operand select, ALU, condition evaluation ----
    always_comb begin
        alu_a_p0 = '0;
        case (bus.E_icode)
            I_RRMOVQ, I_OPQ:              alu_a_p0 = bus.E_valA;
            I_IRMOVQ, I_RMMOVQ, I_MRMOVQ: alu_a_p0 = bus.E_valC;
            I_CALL, I_PUSHQ:              alu_a_p0 = {{(W-4){1'b1}}, 4'b1000};
            I_RET, I_POPQ:                alu_a_p0 = W'(8);
            default:                      alu_a_p0 = '0;
        endcase
    end

    always_comb begin
        alu_b_p0 = '0;
        case (bus.E_icode)
            I_RMMOVQ, I_MRMOVQ, I_OPQ, I_CALL, I_RET, I_PUSHQ, I_POPQ:
                alu_b_p0 = bus.E_valB;
            default:
                alu_b_p0 = '0;
        endcase
    end

    assign alu_fun_p0 = (bus.E_icode == I_OPQ) ? bus.E_ifun : 4'h0;

    always_comb begin
        alu_r_p0  = '0;
        alu_of_p0 = 1'b0;
        alu_ok_p0 = 1'b1;
        case (alu_fun_p0)
            4'h0: begin
                alu_r_p0  = alu_b_p0 + alu_a_p0;
                alu_of_p0 = ovf_add(alu_a_p0, alu_b_p0, alu_r_p0);
            end
            4'h1: begin
                alu_r_p0  = alu_b_p0 - alu_a_p0;
                alu_of_p0 = ovf_sub(alu_a_p0, alu_b_p0, alu_r_p0);
            end
            4'h2: alu_r_p0 = alu_b_p0 & alu_a_p0;
            4'h3: alu_r_p0 = alu_b_p0 ^ alu_a_p0;
`ifdef EXEC_EXT_ALU_EN
            4'h4: alu_r_p0 = alu_b_p0 | alu_a_p0;
            4'h5: alu_r_p0 = alu_b_p0 << alu_a_p0[5:0];
            4'h6: alu_r_p0 = alu_b_p0 >> alu_a_p0[5:0];
`endif
            default: alu_ok_p0 = 1'b0;
        endcase
    end

    // Unsupported OPq yields valE=0 (ALU default) and never touches cc.
    assign op_bad_p0 = (bus.E_icode == I_OPQ) && !alu_ok_p0;
    assign set_cc_p0 = (bus.E_icode == I_OPQ) && alu_ok_p0
                       && !stat_exc(bus.m_stat) && !stat_exc(bus.W_stat);
    assign stat_p0   = (op_bad_p0 && (bus.E_stat == S_AOK)) ? S_INS : bus.E_stat;

    // cc_p1 = {ZF, SF, OF}
    always_comb begin
        cnd_p0 = 1'b1;
        if ((bus.E_icode == I_RRMOVQ) || (bus.E_icode == I_JXX)) begin
            case (bus.E_ifun)
                4'h0:    cnd_p0 = 1'b1;
                4'h1:    cnd_p0 = (cc_p1[1] ^ cc_p1[0]) | cc_p1[2];
                4'h2:    cnd_p0 = cc_p1[1] ^ cc_p1[0];
                4'h3:    cnd_p0 = cc_p1[2];
                4'h4:    cnd_p0 = ~cc_p1[2];
                4'h5:    cnd_p0 = ~(cc_p1[1] ^ cc_p1[0]);
                4'h6:    cnd_p0 = ~(cc_p1[1] ^ cc_p1[0]) & ~cc_p1[2];
                default: cnd_p0 = 1'b0;
            endcase
        end
    end

    assign dst_e_p0 = ((bus.E_icode == I_RRMOVQ) && !cnd_p0) ? RNONE : bus.E_dstE;

    assign bus.e_valE = alu_r_p0;
    assign bus.e_dstE = dst_e_p0;
    assign bus.e_Cnd  = cnd_p0;

    // ---- stage p1: condition codes and M register ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cc_p1 <= 3'b100;
        end else if (set_cc_p0) begin
            cc_p1 <= {(alu_r_p0 == '0), alu_r_p0[W-1], alu_of_p0};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_p1  <= S_AOK;
            icode_p1 <= I_NOP;
            cnd_p1   <= 1'b0;
            val_e_p1 <= '0;
            val_a_p1 <= '0;
            dst_e_p1 <= RNONE;
            dst_m_p1 <= RNONE;
        end else if (bus.M_bubble) begin
            stat_p1  <= S_AOK;
            icode_p1 <= I_NOP;
            cnd_p1   <= 1'b0;
            val_e_p1 <= '0;
            val_a_p1 <= '0;
            dst_e_p1 <= RNONE;
            dst_m_p1 <= RNONE;
        end else begin
            stat_p1  <= stat_p0;
            icode_p1 <= bus.E_icode;
            cnd_p1   <= cnd_p0;
            val_e_p1 <= alu_r_p0;
            val_a_p1 <= bus.E_valA;
            dst_e_p1 <= dst_e_p0;
            dst_m_p1 <= bus.E_dstM;
        end
    end

    assign bus.cc      = cc_p1;
    assign bus.M_stat  = stat_p1;
    assign bus.M_icode = icode_p1;
    assign bus.M_Cnd   = cnd_p1;
    assign bus.M_valE  = val_e_p1;
    assign bus.M_valA  = val_a_p1;
    assign bus.M_dstE  = dst_e_p1;
    assign bus.M_dstM  = dst_m_p1;
endmodule

// File: tb/tb_execute_stage.sv
// -----------------------------------------------------------------------------
// tb_execute_stage
//   Directed vectors for execute_stage. Each issued vector pushes its expected
//   combinational result and its expected M-register/cc contents into queues;
//   independent monitors pop and compare at the falling edge (combinational
//   outputs) and just after the next rising edge (registered outputs).
//   Build option EXEC_EXT_ALU_EN selects the matching expectations.
// -----------------------------------------------------------------------------
module tb_execute_stage;
    logic clk;
    logic rst_n;

    execute_stage_if #(.W(64)) bus ();

    execute_stage #(.W(64), .RNONE(4'hF)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        string       tag;
        logic [63:0] val_e;
        logic [3:0]  dst_e;
        logic        cnd;
    } comb_t;

    typedef struct {
        string       tag;
        logic [2:0]  stat;
        logic [3:0]  icode;
        logic        cnd;
        logic [63:0] val_e;
        logic [63:0] val_a;
        logic [3:0]  dst_e;
        logic [3:0]  dst_m;
        logic [2:0]  cc;
    } reg_t;

    comb_t comb_q[$];
    reg_t  reg_q[$];
    int    n_pass  = 0;
    int    n_total = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        else
            n_pass++;
    endtask

    // Combinational monitor: vectors are driven 3 time units after a rising edge.
    initial begin
        comb_t c;
        forever begin
            @(negedge clk);
            if (comb_q.size() > 0) begin
                c = comb_q.pop_front();
                chk({c.tag, ".e_valE"}, bus.e_valE, c.val_e);
                chk({c.tag, ".e_dstE"}, {60'd0, bus.e_dstE}, {60'd0, c.dst_e});
                chk({c.tag, ".e_Cnd"},  {63'd0, bus.e_Cnd},  {63'd0, c.cnd});
            end
        end
    end

    // Registered monitor: samples one time unit after each rising edge.
    initial begin
        reg_t r;
        forever begin
            @(posedge clk);
            #1;
            if (reg_q.size() > 0) begin
                r = reg_q.pop_front();
                chk({r.tag, ".M_stat"},  {61'd0, bus.M_stat},  {61'd0, r.stat});
                chk({r.tag, ".M_icode"}, {60'd0, bus.M_icode}, {60'd0, r.icode});
                chk({r.tag, ".M_Cnd"},   {63'd0, bus.M_Cnd},   {63'd0, r.cnd});
                chk({r.tag, ".M_valE"},  bus.M_valE,           r.val_e);
                chk({r.tag, ".M_valA"},  bus.M_valA,           r.val_a);
                chk({r.tag, ".M_dstE"},  {60'd0, bus.M_dstE},  {60'd0, r.dst_e});
                chk({r.tag, ".M_dstM"},  {60'd0, bus.M_dstM},  {60'd0, r.dst_m});
                chk({r.tag, ".cc"},      {61'd0, bus.cc},      {61'd0, r.cc});
            end
        end
    end

    task automatic issue(
        input string tag,
        input logic [2:0] st, input logic [3:0] ic, input logic [3:0] fn,
        input logic [63:0] vc, input logic [63:0] va, input logic [63:0] vb,
        input logic [3:0] de, input logic [3:0] dm,
        input logic [2:0] ms, input logic [2:0] ws, input logic bub,
        input logic [63:0] x_val_e, input logic [3:0] x_dst_e, input logic x_cnd,
        input logic [2:0] x_mstat, input logic [2:0] x_cc
    );
        comb_t c;
        reg_t  r;
        @(posedge clk);
        #3;
        bus.E_stat   = st;
        bus.E_icode  = ic;
        bus.E_ifun   = fn;
        bus.E_valC   = vc;
        bus.E_valA   = va;
        bus.E_valB   = vb;
        bus.E_dstE   = de;
        bus.E_dstM   = dm;
        bus.m_stat   = ms;
        bus.W_stat   = ws;
        bus.M_bubble = bub;
        c.tag = tag; c.val_e = x_val_e; c.dst_e = x_dst_e; c.cnd = x_cnd;
        comb_q.push_back(c);
        r.tag = tag;
        r.cc  = x_cc;
        if (bub) begin
            r.stat = 3'd1; r.icode = 4'h1; r.cnd = 1'b0; r.val_e = 64'd0;
            r.val_a = 64'd0; r.dst_e = 4'hF; r.dst_m = 4'hF;
        end else begin
            r.stat = x_mstat; r.icode = ic; r.cnd = x_cnd; r.val_e = x_val_e;
            r.val_a = va; r.dst_e = x_dst_e; r.dst_m = dm;
        end
        reg_q.push_back(r);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n        = 1'b0;
        bus.E_stat   = 3'd1;
        bus.E_icode  = 4'h1;
        bus.E_ifun   = 4'h0;
        bus.E_valC   = 64'd0;
        bus.E_valA   = 64'd0;
        bus.E_valB   = 64'd0;
        bus.E_dstE   = 4'hF;
        bus.E_dstM   = 4'hF;
        bus.m_stat   = 3'd1;
        bus.W_stat   = 3'd1;
        bus.M_bubble = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst.cc",      {61'd0, bus.cc},      64'h4);
        chk("rst.M_stat",  {61'd0, bus.M_stat},  64'h1);
        chk("rst.M_icode", {60'd0, bus.M_icode}, 64'h1);
        chk("rst.M_Cnd",   {63'd0, bus.M_Cnd},   64'h0);
        chk("rst.M_valE",  bus.M_valE,           64'h0);
        chk("rst.M_valA",  bus.M_valA,           64'h0);
        chk("rst.M_dstE",  {60'd0, bus.M_dstE},  64'hF);
        chk("rst.M_dstM",  {60'd0, bus.M_dstM},  64'hF);
        @(negedge clk);
        rst_n = 1'b1;

        //    tag          st ic    fn    valC     valA                   valB                   dE    dM    m  W  bub  e_valE                 e_dstE cnd Mst cc
        issue("nop",       1, 4'h1, 4'h0, 64'h0,   64'h0,                 64'h0,                 4'hF, 4'hF, 1, 1, 0,   64'h0,                 4'hF, 1, 1, 3'b100);
        issue("sub",       1, 4'h6, 4'h1, 64'h0,   64'h5,                 64'h3,                 4'h2, 4'hF, 1, 1, 0,   64'hFFFF_FFFF_FFFF_FFFE, 4'h2, 1, 1, 3'b010);
        issue("cmovl_t",   1, 4'h2, 4'h2, 64'h0,   64'h55,                64'h0,                 4'h3, 4'hF, 1, 1, 0,   64'h55,                4'h3, 1, 1, 3'b010);
        issue("add_ovf",   1, 4'h6, 4'h0, 64'h0,   64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 4'h4, 4'hF, 1, 1, 0, 64'hFFFF_FFFF_FFFF_FFFE, 4'h4, 1, 1, 3'b011);
        issue("xor_zero",  1, 4'h6, 4'h3, 64'h0,   64'h1234,              64'h1234,              4'h4, 4'hF, 1, 1, 0,   64'h0,                 4'h4, 1, 1, 3'b100);
        issue("add_wadr",  1, 4'h6, 4'h0, 64'h0,   64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 4'h4, 4'hF, 1, 3, 0, 64'hFFFF_FFFF_FFFF_FFFE, 4'h4, 1, 1, 3'b100);
        issue("cmovl_nt",  1, 4'h2, 4'h2, 64'h0,   64'h77,                64'h0,                 4'h3, 4'hF, 1, 1, 0,   64'h77,                4'hF, 0, 1, 3'b100);
        issue("pushq",     1, 4'hA, 4'h0, 64'h0,   64'hABC,               64'h100,               4'h4, 4'hF, 1, 1, 0,   64'hF8,                4'h4, 1, 1, 3'b100);
        issue("push_bub",  1, 4'hA, 4'h0, 64'h0,   64'hABC,               64'h100,               4'h4, 4'hF, 1, 1, 1,   64'hF8,                4'h4, 1, 1, 3'b100);
`ifdef EXEC_EXT_ALU_EN
        issue("shl",       1, 4'h6, 4'h5, 64'h0,   64'h4,                 64'h1,                 4'h5, 4'hF, 1, 1, 0,   64'h10,                4'h5, 1, 1, 3'b000);
        issue("je",        1, 4'h7, 4'h3, 64'h40,  64'h0,                 64'h0,                 4'hF, 4'hF, 1, 1, 0,   64'h0,                 4'hF, 0, 1, 3'b000);
`else
        issue("shl_bad",   1, 4'h6, 4'h5, 64'h0,   64'h4,                 64'h1,                 4'h5, 4'hF, 1, 1, 0,   64'h0,                 4'h5, 1, 4, 3'b100);
        issue("je",        1, 4'h7, 4'h3, 64'h40,  64'h0,                 64'h0,                 4'hF, 4'hF, 1, 1, 0,   64'h0,                 4'hF, 1, 1, 3'b100);
`endif
        issue("and",       1, 4'h6, 4'h2, 64'h0,   64'hF0F0,              64'h0FF0,              4'h6, 4'hF, 1, 1, 0,   64'hF0,                4'h6, 1, 1, 3'b000);
        issue("sub_mins",  1, 4'h6, 4'h1, 64'h0,   64'h1,                 64'h1,                 4'h6, 4'hF, 4, 1, 0,   64'h0,                 4'h6, 1, 1, 3'b000);
        issue("bad_hlt",   2, 4'h6, 4'h9, 64'h0,   64'h1,                 64'h1,                 4'h5, 4'hF, 1, 1, 0,   64'h0,                 4'h5, 1, 2, 3'b000);
        issue("ret",       1, 4'h9, 4'h0, 64'h0,   64'h300,               64'h200,               4'h4, 4'hF, 1, 1, 0,   64'h208,               4'h4, 1, 1, 3'b000);
        issue("mrmovq",    1, 4'h5, 4'h0, 64'h10,  64'h0,                 64'h20,                4'hF, 4'h7, 1, 1, 0,   64'h30,                4'hF, 1, 1, 3'b000);
        issue("sub_pre",   1, 4'h6, 4'h1, 64'h0,   64'h5,                 64'h3,                 4'h2, 4'hF, 1, 1, 0,   64'hFFFF_FFFF_FFFF_FFFE, 4'h2, 1, 1, 3'b010);

        // Asynchronous reset in the middle of a cycle with an OPq still in E.
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst.cc",      {61'd0, bus.cc},      64'h4);
        chk("midrst.M_icode", {60'd0, bus.M_icode}, 64'h1);
        chk("midrst.M_valE",  bus.M_valE,           64'h0);
        chk("midrst.M_dstE",  {60'd0, bus.M_dstE},  64'hF);
        @(posedge clk);
        #1;
        chk("midrst_hold.cc", {61'd0, bus.cc},      64'h4);
        rst_n = 1'b1;

        chk("drain.comb_q", 64'(comb_q.size()), 64'd0);
        chk("drain.reg_q",  64'(reg_q.size()),  64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
